// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster timing generator.
package vga_timing_pkg;

  // 11-bit unsigned raster counter type (each total must stay <= 2047)
  typedef logic [10:0] cnt11_t;

  // 640x480@60 timing set
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Clocks per line
  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Lines per frame
  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Fixed-depth shift register with a synchronous reset value.
// Carries the registered {HS, VS, BLANK_N} video controls so they line up
// with pixel data that arrives READ_LEAD clocks after READ_Request.
module vga_sig_delay #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  // Shift one stage per clock; reset loads every stage with the inactive value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Free-running H/V counters, a registered
// pixel-read strobe (READ_Request) and sync/blank outputs delayed by
// READ_LEAD clocks so that they line up with the frame-buffer read data.
// Valid/ready note: READ_Request is a pure strobe with no back-pressure;
// the frame buffer must deliver one pixel for every cycle it is high.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit SYNC_POL  = 1'b0,
  parameter int READ_LEAD = 2
) (
  input  logic   VGA_CLK,
  input  logic   RESET,
  output logic   VGA_HS,
  output logic   VGA_VS,
  output logic   VGA_BLANK_N,
  output logic   VGA_SYNC_N,
  output logic   READ_Request,
  output logic   FRAME_START,
  output cnt11_t H_Cnt,
  output cnt11_t V_Cnt
);

  localparam int     H_TOT      = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int     V_TOT      = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam cnt11_t H_LAST     = cnt11_t'(H_TOT - 1);
  localparam cnt11_t V_LAST     = cnt11_t'(V_TOT - 1);
  localparam cnt11_t H_ACT_END  = cnt11_t'(H_ACTIVE);
  localparam cnt11_t V_ACT_END  = cnt11_t'(V_ACTIVE);
  localparam cnt11_t H_SYNC_BEG = cnt11_t'(H_ACTIVE + H_FP);
  localparam cnt11_t H_SYNC_END = cnt11_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt11_t V_SYNC_BEG = cnt11_t'(V_ACTIVE + V_FP);
  localparam cnt11_t V_SYNC_END = cnt11_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic   SYNC_ACT   = SYNC_POL;
  localparam logic   SYNC_IDLE  = ~SYNC_POL;

  cnt11_t r_h_cnt;
  cnt11_t r_v_cnt;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_act_h;
  logic   w_act_v;
  logic   w_hs_c;
  logic   w_vs_c;
  logic   w_first_px;
  logic   r_read_req;
  logic   r_frame_start;
  logic   r_hs1;
  logic   r_vs1;
  logic [2:0] w_dly_in;
  logic [2:0] w_dly_out;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  // Raster counters; reset parks V at the top of vertical sync so the first
  // frame always opens with a full VS pulse
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_h_cnt <= '0;
      r_v_cnt <= V_SYNC_BEG;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + cnt11_t'(1);
      if (w_h_wrap) r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + cnt11_t'(1);
    end
  end

  // Stage 0: region decode straight from the counters
  always_comb begin
    w_act_h    = (r_h_cnt < H_ACT_END);
    w_act_v    = (r_v_cnt < V_ACT_END);
    w_hs_c     = ((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END)) ? SYNC_ACT : SYNC_IDLE;
    w_vs_c     = ((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END)) ? SYNC_ACT : SYNC_IDLE;
    w_first_px = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Stage 1: registered read strobe, frame marker and undelayed syncs
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_read_req    <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs1         <= SYNC_IDLE;
      r_vs1         <= SYNC_IDLE;
    end else begin
      r_read_req    <= w_act_h & w_act_v;
      r_frame_start <= w_first_px;
      r_hs1         <= w_hs_c;
      r_vs1         <= w_vs_c;
    end
  end

  // BLANK_N is the same decode as READ_Request, so the stage-1 strobe feeds the delay line
  assign w_dly_in = {r_hs1, r_vs1, r_read_req};

  generate
    if (READ_LEAD > 0) begin : g_delay
      vga_sig_delay #(
        .W      (3),
        .DEPTH  (READ_LEAD),
        .RST_VAL({SYNC_IDLE, SYNC_IDLE, 1'b0})
      ) u_delay (
        .i_clk(VGA_CLK),
        .i_rst(RESET),
        .i_d  (w_dly_in),
        .o_q  (w_dly_out)
      );
    end else begin : g_no_delay
      assign w_dly_out = w_dly_in;
    end
  endgenerate

  assign VGA_HS       = w_dly_out[2];
  assign VGA_VS       = w_dly_out[1];
  assign VGA_BLANK_N  = w_dly_out[0];
  assign VGA_SYNC_N   = 1'b0;
  assign READ_Request = r_read_req;
  assign FRAME_START  = r_frame_start;
  assign H_Cnt        = r_h_cnt;
  assign V_Cnt        = r_v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 15x8 raster (H 8/2/3/2, V 4/1/2/1).
// dut: SYNC_POL=0, READ_LEAD=2.  dut_l0: SYNC_POL=1, READ_LEAD=0.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs, vs, bn, sn, rd, fs;
  logic [10:0] hc, vc;
  logic        hs0, vs0, bn0, sn0, rd0, fs0;
  logic [10:0] hc0, vc0;

  int checks   = 0;
  int failures = 0;
  int t_cur    = 0;

  typedef struct {
    int t; int h; int v;
    bit rd; bit fs; bit bn; bit hs; bit vs;
  } vec_t;
  vec_t vecs[$];

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .READ_LEAD(2)
  ) dut (
    .VGA_CLK(clk), .RESET(rst), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bn),
    .VGA_SYNC_N(sn), .READ_Request(rd), .FRAME_START(fs), .H_Cnt(hc), .V_Cnt(vc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .READ_LEAD(0)
  ) dut_l0 (
    .VGA_CLK(clk), .RESET(rst), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0),
    .VGA_SYNC_N(sn0), .READ_Request(rd0), .FRAME_START(fs0), .H_Cnt(hc0), .V_Cnt(vc0)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    t_cur++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0d: actual=%0d expected=%0d", name, t_cur, act, exp);
    end
  endtask

  // Advance until FRAME_START is seen on dut; bounded
  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int lead_bad, hs_bad, vs_bad, l0_bad, hist_n;
    int rd_cnt, rise_cnt, fs_cnt, vs_lo, hs_lo, vs0_hi, hs0_hi, fs0_cnt;
    int bad_runs, run_len;
    logic prev_rd;
    logic rd_h[$];
    int hh[$];
    int vh[$];
    bit ok;

    // t = cycles after the last reset-loading edge.
    // Counters at t: H=t%15, V=(5+t/15)%8. READ_Request(t) decodes counters at t-1;
    // HS/VS/BLANK_N(t) decode counters at t-3 (inactive before t=3).
    //                t    h  v  rd fs bn hs vs
    vecs.push_back('{  0,  0, 5, 0, 0, 0, 1, 1});
    vecs.push_back('{  3,  3, 5, 0, 0, 0, 1, 0});
    vecs.push_back('{ 13, 13, 5, 0, 0, 0, 0, 0});
    vecs.push_back('{ 16,  1, 6, 0, 0, 0, 1, 0});
    vecs.push_back('{ 32,  2, 7, 0, 0, 0, 1, 0});
    vecs.push_back('{ 33,  3, 7, 0, 0, 0, 1, 1});
    vecs.push_back('{ 44, 14, 7, 0, 0, 0, 0, 1});
    vecs.push_back('{ 45,  0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{ 46,  1, 0, 1, 1, 0, 1, 1});
    vecs.push_back('{ 47,  2, 0, 1, 0, 0, 1, 1});
    vecs.push_back('{ 48,  3, 0, 1, 0, 1, 1, 1});
    vecs.push_back('{ 53,  8, 0, 1, 0, 1, 1, 1});
    vecs.push_back('{ 54,  9, 0, 0, 0, 1, 1, 1});
    vecs.push_back('{ 56, 11, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{ 58, 13, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{ 61,  1, 1, 1, 0, 0, 1, 1});
    vecs.push_back('{166,  1, 0, 1, 1, 0, 1, 1});

    // Reset: three edges with RESET high; the last one is t=0
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    t_cur = 0;

    // Table-driven directed vectors
    foreach (vecs[k]) begin
      while (t_cur < vecs[k].t) tick();
      check("h_cnt",       int'(hc),  vecs[k].h);
      check("v_cnt",       int'(vc),  vecs[k].v);
      check("read_req",    int'(rd),  int'(vecs[k].rd));
      check("frame_start", int'(fs),  int'(vecs[k].fs));
      check("blank_n",     int'(bn),  int'(vecs[k].bn));
      check("hs",          int'(hs),  int'(vecs[k].hs));
      check("vs",          int'(vs),  int'(vecs[k].vs));
      check("l0_read_req", int'(rd0), int'(vecs[k].rd));
      check("l0_blank_n",  int'(bn0), int'(vecs[k].rd));
      check("sync_n",      int'(sn),  0);
    end

    // Lead and sync-decode checks on every clock of 3 frames
    lead_bad = 0; hs_bad = 0; vs_bad = 0; l0_bad = 0; hist_n = 0;
    for (int i = 0; i < 360; i++) begin
      if (rd_h.size() == 2 && bn !== rd_h[0]) lead_bad++;
      if (hh.size() == 3) begin
        hist_n++;
        if (hs !== (((hh[0] >= 10) && (hh[0] < 13)) ? 1'b0 : 1'b1)) hs_bad++;
        if (vs !== (((vh[0] == 5) || (vh[0] == 6)) ? 1'b0 : 1'b1)) vs_bad++;
      end
      if (bn0 !== rd0) l0_bad++;
      rd_h.push_back(rd);
      hh.push_back(int'(hc));
      vh.push_back(int'(vc));
      if (rd_h.size() > 2) void'(rd_h.pop_front());
      if (hh.size() > 3) begin
        void'(hh.pop_front());
        void'(vh.pop_front());
      end
      tick();
    end
    check("lead2_mismatches",   lead_bad, 0);
    check("hs_decode_mismatch", hs_bad,   0);
    check("vs_decode_mismatch", vs_bad,   0);
    check("lead0_mismatches",   l0_bad,   0);
    check("history_samples",    hist_n,   357);

    // Steady frame statistics over one 120-clock frame
    wait_fs(ok);
    check("fs_seen", int'(ok), 1);
    rd_cnt = 0; rise_cnt = 0; fs_cnt = 0; vs_lo = 0; hs_lo = 0;
    vs0_hi = 0; hs0_hi = 0; fs0_cnt = 0; bad_runs = 0; run_len = 0;
    prev_rd = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (rd) begin
        rd_cnt++;
        run_len++;
        if (!prev_rd) rise_cnt++;
      end else if (prev_rd) begin
        if (run_len != 8) bad_runs++;
        run_len = 0;
      end
      if (fs) fs_cnt++;
      if (fs0) fs0_cnt++;
      if (!vs) vs_lo++;
      if (!hs) hs_lo++;
      if (vs0) vs0_hi++;
      if (hs0) hs0_hi++;
      prev_rd = rd;
      tick();
    end
    check("reads_per_frame",  rd_cnt,   32);
    check("runs_per_frame",   rise_cnt, 4);
    check("bad_run_lengths",  bad_runs, 0);
    check("fs_per_frame",     fs_cnt,   1);
    check("fs_period_120",    int'(fs), 1);
    check("vs_active_clks",   vs_lo,    30);
    check("hs_active_clks",   hs_lo,    24);
    check("l0_vs_active_pos", vs0_hi,   30);
    check("l0_hs_active_pos", hs0_hi,   24);
    check("l0_fs_per_frame",  fs0_cnt,  1);

    // Wrap corner: H=14,V=7 -> both 0 -> FRAME_START with READ_Request
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (hc == 11'd14 && vc == 11'd7) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("wrap_found", int'(ok), 1);
    tick();
    check("wrap_h_zero", int'(hc), 0);
    check("wrap_v_zero", int'(vc), 0);
    tick();
    check("wrap_fs", int'(fs), 1);
    check("wrap_rd", int'(rd), 1);

    // Mid-frame reset at V=2, H=4
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (hc == 11'd4 && vc == 11'd2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("midrst_found", int'(ok), 1);
    check("midrst_pre_rd", int'(rd), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rd",  int'(rd), 0);
    check("midrst_bn",  int'(bn), 0);
    check("midrst_h",   int'(hc), 0);
    check("midrst_v",   int'(vc), 5);
    check("midrst_hs",  int'(hs), 1);
    check("midrst_vs",  int'(vs), 1);
    rd_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rd) rd_cnt++;
      if (bn) fs_cnt++;
    end
    check("midrst_no_reads", rd_cnt, 0);
    check("midrst_no_blank", fs_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
